ss_arbiter: RTL

Round-robin arbiter that shares the single 8-digit seven-segment display between four requesters, such as a CPU register view, a memory view, a debug probe and a status page. It sits directly upstream of the seven-segment scan driver. Each requester presents a full display image: four data bytes, two hex digits per byte, plus an 8-bit digit-enable mask. The arbiter grants ownership to one requester at a time and enforces a minimum hold time so that displayed values remain readable. A debug pin mode lets a board switch force a single source.

---
 rtl/ss_arbiter_if.sv | 20 ++
 rtl/ss_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/ss_arbiter_if.sv
// ss_arbiter_if: requester images in, granted display image and arbitration status out
interface ss_arbiter_if;
  logic [3:0] req;
  logic [31:0] d0, d1, d2, d3;
  logic [7:0] m0, m1, m2, m3;
  logic pin_en;
  logic [1:0] pin_sel;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic busy, sw_pulse;
  logic [7:0] mask, r0, r1, r2, r3;
  modport master (
    output req, d0, d1, d2, d3, m0, m1, m2, m3, pin_en, pin_sel,
    input gnt, owner, busy, sw_pulse, mask, r0, r1, r2, r3
  );
  modport slave (
    input req, d0, d1, d2, d3, m0, m1, m2, m3, pin_en, pin_sel,
    output gnt, owner, busy, sw_pulse, mask, r0, r1, r2, r3
  );
endinterface

// File: rtl/ss_arbiter.sv
// ss_arbiter: round-robin seven-segment display owner with minimum hold time and pin override
module ss_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic clk,
  input logic rst,
  ss_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWN} state_t;
  localparam logic [31:0] RELOAD = 32'(HOLD_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] owner_n, last, last_n, pick, idx;
  logic [31:0] cnt, cnt_n;
  logic [3:0] oth, gnt_n;
  logic found;
  logic [31:0] d [4];
  logic [7:0] m [4];
  assign d = '{bus.d0, bus.d1, bus.d2, bus.d3};
  assign m = '{bus.m0, bus.m1, bus.m2, bus.m3};
  // candidates exclude the current owner, so the search never re-picks it
  always_comb begin
    oth = bus.req & ((state == OWN) ? ~(4'b0001 << bus.owner) : 4'b1111);
    pick = last;
    found = 1'b0;
    idx = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && oth[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
    state_n = state;
    owner_n = bus.owner;
    last_n = last;
    cnt_n = cnt;
    if (bus.pin_en) begin
      state_n = bus.req[bus.pin_sel] ? OWN : IDLE;
      owner_n = bus.req[bus.pin_sel] ? bus.pin_sel : bus.owner;
      cnt_n = RELOAD;
    end else if (state == IDLE || !bus.req[bus.owner] || cnt == 0) begin
      if (found) begin
        state_n = OWN;
        owner_n = pick;
        last_n = pick;
        cnt_n = RELOAD;
      end else if (state == IDLE || !bus.req[bus.owner]) begin
        state_n = IDLE;
      end
    end else begin
      cnt_n = cnt - 32'd1;
    end
    gnt_n = (state_n == OWN) ? (4'b0001 << owner_n) : 4'b0000;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bus.owner <= 2'd0;
      last <= 2'd3;
      cnt <= 32'd0;
      bus.gnt <= 4'b0000;
      bus.busy <= 1'b0;
      bus.sw_pulse <= 1'b0;
      bus.mask <= 8'h00;
      {bus.r3, bus.r2, bus.r1, bus.r0} <= 32'h0;
    end else begin
      state <= state_n;
      bus.owner <= owner_n;
      last <= last_n;
      cnt <= cnt_n;
      bus.gnt <= gnt_n;
      bus.busy <= state_n == OWN;
      bus.sw_pulse <= gnt_n != bus.gnt;
      bus.mask <= (state == OWN) ? m[bus.owner] : 8'h00;
      {bus.r3, bus.r2, bus.r1, bus.r0} <= (state == OWN) ? d[bus.owner] : 32'h0;
    end
  end
endmodule
